// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg
//   Shared constants for the RAM stream reader: default RAM geometry,
//   FSM state encoding and the depth of the output skid buffer.
//   No ports.
package ram_stream_pkg;

    localparam int ADDR_W_DEF = 14;  // 16K words
    localparam int DATA_W_DEF = 2;   // 2-bit words
    localparam int BUF_DEPTH  = 2;   // one slot for RAM latency, one for backpressure

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2
//   Two-entry synchronous FIFO. Simultaneous push and pop are both honoured.
//   Ports:
//     clka       clock, rising edge
//     rsta       synchronous active-low reset; empties the FIFO, zeroes data
//     push       write push_data at the tail
//     push_data  data to write
//     pop        drop the head entry (ignored when empty)
//     head       current head entry
//     count      number of valid entries, 0..2
module stream_fifo2
    import ram_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [DATA_W-1:0] ent0, ent1;
    logic [1:0]        cnt;
    logic              do_pop, do_push;

    // Guard against misuse so the entry pointers can never go out of range.
    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != FULL) || do_pop);

    always_ff @(posedge clka) begin
        if (!rsta) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= push_data;
                    else             ent1 <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever remains.
                    if (cnt == FULL) begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end else begin
                        ent0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = ent0;
    assign count = cnt;

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Reads a contiguous window of the single-port block RAM on a start pulse
//   and streams the words out over valid/ready. Owns the RAM port while busy.
//   Ports:
//     clka, rsta         clock; synchronous active-low reset
//     start              request, sampled only in IDLE
//     base_addr, length  window start and word count (0..2**ADDR_W), captured with start
//     busy               high in RUN and DRAIN
//     done               one-cycle pulse after the last beat (or for length 0)
//     ram_ena/wea/addra  RAM control; wea tied low
//     ram_douta          RAM read data, valid the cycle after ram_ena
//     m_data/m_valid     stream output
//     m_ready            stream ready; beat transfers on m_valid && m_ready
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    input  logic [DATA_W-1:0] ram_douta,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam logic [2:0]    OCC_LIM = 3'(BUF_DEPTH);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued;
    logic [ADDR_W:0]   accepted;
    logic              inflight;   // read issued last cycle, data on ram_douta now

    logic [1:0]        buf_count;
    logic [DATA_W-1:0] buf_head;
    logic              buf_empty;
    logic              pop, fifo_push, fifo_pop, issue;
    logic [2:0]        occ_next;

    assign buf_empty = (buf_count == 2'd0);

    // The in-flight word counts as the buffer's pending entry: when the buffer
    // is empty it is presented straight from ram_douta, which is what gives
    // first m_valid two cycles after start. If it is not taken, it is pushed
    // and re-presented from the buffer, so m_data holds across the stall.
    assign m_valid = !buf_empty || inflight;
    assign m_data  = !buf_empty ? buf_head : (inflight ? ram_douta : '0);

    assign pop       = m_valid && m_ready;
    assign fifo_pop  = pop && !buf_empty;
    assign fifo_push = inflight && !(buf_empty && m_ready);

    // Occupancy after this cycle's transfer; m_ready feeds ram_ena here on
    // purpose so a full buffer being drained can still issue at full rate.
    assign occ_next = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};
    assign issue    = (state == ST_RUN) && (issued < len_q) && (occ_next < OCC_LIM);

    assign ram_ena   = issue;
    assign ram_wea   = 1'b0;
    assign ram_addra = issue ? (base_q + issued[ADDR_W-1:0]) : '0;  // wraps mod 2**ADDR_W

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_FIN);

    stream_fifo2 #(.DATA_W(DATA_W)) u_buf (
        .clka      (clka),
        .rsta      (rsta),
        .push      (fifo_push),
        .push_data (ram_douta),
        .pop       (fifo_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    always_ff @(posedge clka) begin
        if (!rsta) begin
            state    <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            accepted <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) issued   <= issued + ONE;
            if (pop)   accepted <= accepted + ONE;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        len_q    <= length;
                        issued   <= '0;
                        accepted <= '0;
                        state    <= (length == '0) ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue && (issued + ONE == len_q)) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Last beat leaving implies buffer empty and nothing in flight.
                    if (pop && (accepted + ONE == len_q)) state <= ST_FIN;
                end
                default: state <= ST_IDLE;  // ST_FIN
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;

    localparam int AW = 14;
    localparam int DW = 2;

    logic          clka = 1'b0;
    logic          rsta = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, ram_ena, ram_wea, m_valid;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_douta = '0;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_q [$];

    int checks = 0;
    int errors = 0;

    ram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clka      (clka),
        .rsta      (rsta),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_douta (ram_douta),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 clka = ~clka;

    // Block RAM model: one-cycle read latency.
    always @(posedge clka) if (ram_ena) ram_douta <= mem[ram_addra];

    // Drive a start pulse on the current cycle (cycle 0) and queue expectations.
    task automatic kick(input logic [AW-1:0] b, input logic [AW:0] n);
        @(negedge clka);
        base_addr = b;
        length    = n;
        start     = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(mem[AW'(int'(b) + i)]);
            addr_q.push_back(AW'(int'(b) + i));
        end
    endtask

    task automatic test_reset();
        rsta = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge clka);
        #1;
        checks++;
        if ({busy, done, m_valid, ram_ena, ram_wea} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy/done/valid/ena/wea=%b exp 00000",
                     {busy, done, m_valid, ram_ena, ram_wea});
        end
        checks++;
        if (m_data !== '0) begin
            errors++; $display("FAIL reset_mdata got %0d exp 0", m_data);
        end
        checks++;
        if (ram_addra !== '0) begin
            errors++; $display("FAIL reset_addr got %0d exp 0", ram_addra);
        end
        rsta = 1'b1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] e;
        for (int i = 0; i < 8; i++) mem[i] = DW'(i % 4);
        exp_q.delete(); addr_q.delete();
        m_ready = 1'b1;
        kick('0, 9'd8);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clka);
            start = 1'b0;
            #1;
            checks++;
            if (m_valid !== (k >= 2 && k <= 9)) begin
                errors++; $display("FAIL basic_valid cyc %0d got %b", k, m_valid);
            end
            checks++;
            if (busy !== (k >= 1 && k <= 9)) begin
                errors++; $display("FAIL basic_busy cyc %0d got %b", k, busy);
            end
            checks++;
            if (done !== (k == 10)) begin
                errors++; $display("FAIL basic_done cyc %0d got %b", k, done);
            end
            checks++;
            if (ram_ena !== (k >= 1 && k <= 8)) begin
                errors++; $display("FAIL basic_ena cyc %0d got %b", k, ram_ena);
            end
            if (ram_ena && addr_q.size() > 0) begin
                checks++;
                if (ram_addra !== addr_q[0]) begin
                    errors++; $display("FAIL basic_addr got %0d exp %0d", ram_addra, addr_q[0]);
                end
                void'(addr_q.pop_front());
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL basic_extra got %0d exp none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++; $display("FAIL basic_data cyc %0d got %0d exp %0d", k, m_data, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL basic_count got %0d left exp 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e, prev_data;
        int issued_n, accepted_n, outstanding;
        logic prev_stall, seen_done, p;
        exp_q.delete(); addr_q.delete();
        issued_n = 0; accepted_n = 0; prev_stall = 1'b0; seen_done = 1'b0; prev_data = '0;
        m_ready = 1'b1;
        kick('0, 9'd8);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clka);
            start = 1'b0;
            m_ready = (k % 4 == 0) || (k % 4 == 3);
            #1;
            p = m_valid && m_ready;
            if (ram_ena) begin
                outstanding = issued_n - accepted_n - (p ? 1 : 0);
                checks++;
                if (outstanding >= 2) begin
                    errors++; $display("FAIL bp_occupancy cyc %0d got %0d exp <2", k, outstanding);
                end
                if (addr_q.size() > 0) begin
                    checks++;
                    if (ram_addra !== addr_q[0]) begin
                        errors++; $display("FAIL bp_addr got %0d exp %0d", ram_addra, addr_q[0]);
                    end
                    void'(addr_q.pop_front());
                end
                issued_n++;
            end
            if (prev_stall) begin
                checks++;
                if (!m_valid || m_data !== prev_data) begin
                    errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%0d exp v=1 d=%0d",
                                       k, m_valid, m_data, prev_data);
                end
            end
            if (p) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra got %0d exp none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++; $display("FAIL bp_data cyc %0d got %0d exp %0d", k, m_data, e);
                    end
                end
                accepted_n++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
        checks++;
        if (!seen_done) begin
            errors++; $display("FAIL bp_timeout got no done exp done within 60 cycles");
        end
        checks++;
        if (accepted_n != 8 || exp_q.size() != 0) begin
            errors++; $display("FAIL bp_count got %0d beats exp 8", accepted_n);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] e;
        mem[16382] = 2'd3; mem[16383] = 2'd2; mem[0] = 2'd1; mem[1] = 2'd0;
        exp_q.delete(); addr_q.delete();
        m_ready = 1'b1;
        kick(14'd16382, 15'd4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clka);
            start = 1'b0;
            #1;
            if (ram_ena) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++; $display("FAIL wrap_extra_ena got addr %0d exp none", ram_addra);
                end else if (ram_addra !== addr_q.pop_front()) begin
                    errors++; $display("FAIL wrap_addr cyc %0d got %0d", k, ram_addra);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL wrap_extra got %0d exp none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++; $display("FAIL wrap_data got %0d exp %0d", m_data, e);
                    end
                end
            end
            checks++;
            if (done !== (k == 6)) begin
                errors++; $display("FAIL wrap_done cyc %0d got %b", k, done);
            end
        end
        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++; $display("FAIL wrap_count got %0d/%0d left exp 0/0", exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_len0();
        exp_q.delete(); addr_q.delete();
        kick(14'd5, '0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clka);
            start = 1'b0;
            #1;
            checks++;
            if ({ram_ena, m_valid, busy} !== 3'b000) begin
                errors++; $display("FAIL len0_idle cyc %0d got ena/valid/busy=%b exp 000",
                                   k, {ram_ena, m_valid, busy});
            end
            checks++;
            if (done !== (k == 1)) begin
                errors++; $display("FAIL len0_done cyc %0d got %b", k, done);
            end
        end
    endtask

    task automatic test_restart();
        logic [DW-1:0] e;
        for (int i = 0; i < 8; i++) mem[i] = DW'(i % 4);
        for (int i = 100; i < 103; i++) mem[i] = 2'd3;
        exp_q.delete(); addr_q.delete();
        m_ready = 1'b1;
        kick('0, 9'd8);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clka);
            if (k == 3) begin
                start = 1'b1; base_addr = 14'd100; length = 15'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (ram_ena) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++; $display("FAIL restart_extra_ena got addr %0d exp none", ram_addra);
                end else if (ram_addra !== addr_q.pop_front()) begin
                    errors++; $display("FAIL restart_addr cyc %0d got %0d", k, ram_addra);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL restart_extra got %0d exp none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++; $display("FAIL restart_data cyc %0d got %0d exp %0d", k, m_data, e);
                    end
                end
            end
            checks++;
            if (done !== (k == 10) || busy !== (k <= 9)) begin
                errors++; $display("FAIL restart_ctrl cyc %0d got done=%b busy=%b", k, done, busy);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL restart_count got %0d left exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] e;
        mem[4] = 2'd0; mem[5] = 2'd1;
        exp_q.delete(); addr_q.delete();
        m_ready = 1'b0;
        kick(14'd4, 15'd2);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clka);
            start = 1'b0;
            #1;
        end
        // cycle 4: DRAIN, both words buffered
        checks++;
        if (busy !== 1'b1 || m_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_pre got busy=%b valid=%b exp 1 1", busy, m_valid);
        end
        rsta = 1'b0;
        @(negedge clka);
        #1;
        checks++;
        if ({m_valid, busy, ram_ena, done} !== 4'b0000) begin
            errors++; $display("FAIL rmid_reset got valid/busy/ena/done=%b exp 0000",
                               {m_valid, busy, ram_ena, done});
        end
        rsta = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clka);
            #1;
            checks++;
            if (done !== 1'b0 || m_valid !== 1'b0) begin
                errors++; $display("FAIL rmid_quiet got done=%b valid=%b exp 0 0", done, m_valid);
            end
        end
        exp_q.delete(); addr_q.delete();
        m_ready = 1'b1;
        kick(14'd4, 15'd2);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clka);
            start = 1'b0;
            #1;
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rmid_extra got %0d exp none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++; $display("FAIL rmid_data got %0d exp %0d", m_data, e);
                    end
                end
            end
            checks++;
            if (done !== (k == 4)) begin
                errors++; $display("FAIL rmid_done cyc %0d got %b", k, done);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rmid_count got %0d left exp 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_len0();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
